// File: rtl/flash_boot_loader.sv
// Copies FlashTransferBytes from SPI flash (mode 0, read 0x03 / fast read 0x0B) into RAM as 32-bit words.
// Ports: clk/rst_n (async active-low), start/busy/done handshake, ramio_* word-write master, flash_* SPI master.
// Optional: define FLASH_BOOT_CHECKSUM_EN to add output checksum[31:0] (wrapping sum of written words).
module flash_boot_loader #(
    parameter int unsigned StartupWaitCycles  = 10,
    parameter logic [31:0] FlashTransferBytes = 32'h0010_0000,
    parameter logic [23:0] FlashStartAddress  = 24'h00_0000,
    parameter logic [31:0] RamStartAddress    = 32'h0000_0000,
    parameter int unsigned SpiHalfPeriod      = 1,
    parameter int unsigned FastRead           = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        ramio_enable,
    output logic [1:0]  ramio_write_type,
    output logic [31:0] ramio_address,
    output logic [31:0] ramio_data_in,
    input  logic        ramio_busy,
    output logic        flash_clk,
    input  logic        flash_miso,
    output logic        flash_mosi,
    output logic        flash_cs
`ifdef FLASH_BOOT_CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);

    // A zero startup wait still spends one cycle in Init.
    localparam logic [31:0] WaitLast = (StartupWaitCycles > 0) ? 32'(StartupWaitCycles - 1) : 32'd0;
    localparam logic [15:0] HalfLast = (SpiHalfPeriod > 1) ? 16'(SpiHalfPeriod - 1) : 16'd0;
    localparam logic [7:0]  ReadCmd  = (FastRead != 0) ? 8'h0B : 8'h03;

    typedef enum logic [2:0] {
        Init, SendCmd, SendAddr, Dummy, ReadWord, StartWrite, Write, Done
    } state_t;

    state_t      state, state_next;
    logic [31:0] wait_cnt, wait_cnt_next;
    logic [15:0] phase_cnt, phase_cnt_next;
    logic [4:0]  bit_cnt, bit_cnt_next;      // bits left in the current field, minus one
    logic [31:0] tx_sr, tx_sr_next;          // next mosi bit is always tx_sr[31]
    logic [31:0] rx_sr, rx_sr_next;
    logic [31:0] byte_cnt, byte_cnt_next;    // bytes already written to RAM in this run
    logic        ramio_enable_next;
    logic [1:0]  ramio_write_type_next;
    logic [31:0] ramio_address_next, ramio_data_in_next;
    logic        flash_clk_next, flash_mosi_next, flash_cs_next;
`ifdef FLASH_BOOT_CHECKSUM_EN
    logic [31:0] checksum_next;
`endif

    assign busy = (state != Done);
    assign done = (state == Done);

    always_comb begin
        state_next            = state;
        wait_cnt_next         = wait_cnt;
        phase_cnt_next        = phase_cnt;
        bit_cnt_next          = bit_cnt;
        tx_sr_next            = tx_sr;
        rx_sr_next            = rx_sr;
        byte_cnt_next         = byte_cnt;
        ramio_enable_next     = ramio_enable;
        ramio_write_type_next = ramio_write_type;
        ramio_address_next    = ramio_address;
        ramio_data_in_next    = ramio_data_in;
        flash_clk_next        = flash_clk;
        flash_mosi_next       = flash_mosi;
        flash_cs_next         = flash_cs;
`ifdef FLASH_BOOT_CHECKSUM_EN
        checksum_next         = checksum;
`endif
        case (state)
            Init: begin
                if (wait_cnt == WaitLast) begin
                    if (FlashTransferBytes == 32'd0) begin
                        state_next = Done;
                    end else begin
                        state_next      = SendCmd;
                        flash_cs_next   = 1'b0;
                        flash_mosi_next = ReadCmd[7];
                        tx_sr_next      = {ReadCmd[6:0], 25'd0};
                        bit_cnt_next    = 5'd7;
                        phase_cnt_next  = 16'd0;
                    end
                end else begin
                    wait_cnt_next = wait_cnt + 32'd1;
                end
            end
            SendCmd, SendAddr, Dummy, ReadWord: begin
                if (phase_cnt != HalfLast) begin
                    phase_cnt_next = phase_cnt + 16'd1;
                end else begin
                    phase_cnt_next = 16'd0;
                    if (!flash_clk) begin
                        // Rising edge: the flash has had a full low phase to settle miso.
                        flash_clk_next = 1'b1;
                        if (state == ReadWord) begin
                            rx_sr_next = {rx_sr[30:0], flash_miso};
                        end
                    end else begin
                        // Falling edge starts the next bit's low phase; mosi changes here.
                        flash_clk_next = 1'b0;
                        if (bit_cnt != 5'd0) begin
                            bit_cnt_next    = bit_cnt - 5'd1;
                            flash_mosi_next = tx_sr[31];
                            tx_sr_next      = {tx_sr[30:0], 1'b0};
                        end else if (state == SendCmd) begin
                            state_next      = SendAddr;
                            flash_mosi_next = FlashStartAddress[23];
                            tx_sr_next      = {FlashStartAddress[22:0], 9'd0};
                            bit_cnt_next    = 5'd23;
                        end else if (state == SendAddr && FastRead != 0) begin
                            state_next      = Dummy;
                            flash_mosi_next = 1'b0;
                            tx_sr_next      = 32'd0;
                            bit_cnt_next    = 5'd7;
                        end else if (state == SendAddr || state == Dummy) begin
                            state_next      = ReadWord;
                            flash_mosi_next = 1'b0;
                            tx_sr_next      = 32'd0;
                            bit_cnt_next    = 5'd31;
                        end else begin
                            state_next = StartWrite;
                        end
                    end
                end
            end
            StartWrite: begin
                if (!ramio_busy) begin
                    state_next            = Write;
                    ramio_enable_next     = 1'b1;
                    ramio_write_type_next = 2'b11;
                    ramio_address_next    = RamStartAddress + byte_cnt;
                    // Bytes arrive first-to-last; the first byte lands in the low lane.
                    ramio_data_in_next    = {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
                end
            end
            Write: begin
                if (!ramio_busy) begin
                    ramio_enable_next = 1'b0;
                    byte_cnt_next     = byte_cnt + 32'd4;
`ifdef FLASH_BOOT_CHECKSUM_EN
                    checksum_next     = checksum + ramio_data_in;
`endif
                    if (byte_cnt + 32'd4 >= FlashTransferBytes) begin
                        state_next    = Done;
                        flash_cs_next = 1'b1;
                    end else begin
                        // Flash keeps streaming from where it paused; no new command needed.
                        state_next     = ReadWord;
                        bit_cnt_next   = 5'd31;
                        phase_cnt_next = 16'd0;
                    end
                end
            end
            Done: begin
                if (start) begin
                    state_next    = Init;
                    wait_cnt_next = 32'd0;
                    byte_cnt_next = 32'd0;
`ifdef FLASH_BOOT_CHECKSUM_EN
                    checksum_next = 32'd0;
`endif
                end
            end
            default: state_next = Init;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= Init;
            wait_cnt         <= 32'd0;
            phase_cnt        <= 16'd0;
            bit_cnt          <= 5'd0;
            tx_sr            <= 32'd0;
            rx_sr            <= 32'd0;
            byte_cnt         <= 32'd0;
            ramio_enable     <= 1'b0;
            ramio_write_type <= 2'b00;
            ramio_address    <= 32'd0;
            ramio_data_in    <= 32'd0;
            flash_clk        <= 1'b0;
            flash_mosi       <= 1'b0;
            flash_cs         <= 1'b1;
`ifdef FLASH_BOOT_CHECKSUM_EN
            checksum         <= 32'd0;
`endif
        end else begin
            state            <= state_next;
            wait_cnt         <= wait_cnt_next;
            phase_cnt        <= phase_cnt_next;
            bit_cnt          <= bit_cnt_next;
            tx_sr            <= tx_sr_next;
            rx_sr            <= rx_sr_next;
            byte_cnt         <= byte_cnt_next;
            ramio_enable     <= ramio_enable_next;
            ramio_write_type <= ramio_write_type_next;
            ramio_address    <= ramio_address_next;
            ramio_data_in    <= ramio_data_in_next;
            flash_clk        <= flash_clk_next;
            flash_mosi       <= flash_mosi_next;
            flash_cs         <= flash_cs_next;
`ifdef FLASH_BOOT_CHECKSUM_EN
            checksum         <= checksum_next;
`endif
        end
    end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Bench for flash_boot_loader: instance 0 uses default parameters, instance 1 uses fast read,
// half period 3, 8 bytes to RAM 0x100. Flash is a byte-stream model; RAM writes are checked
// against the expected word sequence every cycle, plus SPI header bits and phase lengths.
module tb_flash_boot_loader;

    logic              clk = 1'b0;
    logic [1:0]        rst_n, start, rbusy, miso;
    logic [1:0]        busy, done, ren, fclk, mosi, cs;
    logic [1:0][1:0]   wtype;
    logic [1:0][31:0]  addr, wdata;
`ifdef FLASH_BOOT_CHECKSUM_EN
    logic [1:0][31:0]  csum;
`endif
    int                rise_arr [2];
    logic [39:0]       hdr_arr  [2];

    always #5 clk = ~clk;

    flash_boot_loader u_def (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .ramio_enable(ren[0]), .ramio_write_type(wtype[0]), .ramio_address(addr[0]),
        .ramio_data_in(wdata[0]), .ramio_busy(rbusy[0]), .flash_clk(fclk[0]),
        .flash_miso(miso[0]), .flash_mosi(mosi[0]), .flash_cs(cs[0])
`ifdef FLASH_BOOT_CHECKSUM_EN
        , .checksum(csum[0])
`endif
    );

    flash_boot_loader #(
        .StartupWaitCycles(4), .FlashTransferBytes(32'd8), .FlashStartAddress(24'hA5_5A3C),
        .RamStartAddress(32'h0000_0100), .SpiHalfPeriod(3), .FastRead(1)
    ) u_fast (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .ramio_enable(ren[1]), .ramio_write_type(wtype[1]), .ramio_address(addr[1]),
        .ramio_data_in(wdata[1]), .ramio_busy(rbusy[1]), .flash_clk(fclk[1]),
        .flash_miso(miso[1]), .flash_mosi(mosi[1]), .flash_cs(cs[1])
`ifdef FLASH_BOOT_CHECKSUM_EN
        , .checksum(csum[1])
`endif
    );

    // Flash content, relative to the start address.
    function automatic logic [7:0] fb(int i);
        if (i < 4) return 8'(8'h11 * (i + 1));
        return 8'((i * 37 + 5) % 256);
    endfunction
    function automatic logic sbit(int j);
        logic [7:0] b;
        if (j < 0) return 1'b0;
        b = fb(j / 8);
        return b[7 - (j % 8)];
    endfunction
    function automatic logic [31:0] fw(int n);
        return {fb(4 * n + 3), fb(4 * n + 2), fb(4 * n + 1), fb(4 * n)};
    endfunction

    function automatic int hdr_len(int k);   return (k == 0) ? 32 : 40; endfunction
    function automatic int wait_of(int k);   return (k == 0) ? 10 : 4;  endfunction
    function automatic int half_of(int k);   return (k == 0) ? 1 : 3;   endfunction
    function automatic logic [31:0] ram_base(int k); return (k == 0) ? 32'h0 : 32'h100; endfunction
    function automatic int words_of(int k);  return (k == 0) ? 32'h40000 : 2; endfunction
    function automatic logic [39:0] hdr_exp(int k);
        return (k == 0) ? 40'h00_0300_0000 : 40'h0B_A55A_3C00;
    endfunction

    // SPI mode-0 flash: captures mosi on rising sclk, shifts miso out on falling sclk.
    for (genvar k = 0; k < 2; k++) begin : g_flash
        localparam int Hdr = (k == 0) ? 32 : 40;
        int          rise = 0;
        logic [39:0] hdr  = '0;
        logic        m    = 1'b0;
        always @(posedge fclk[k] or posedge cs[k]) begin
            if (cs[k]) begin
                rise = 0;
                hdr  = '0;
            end else begin
                if (rise < Hdr) hdr = {hdr[38:0], mosi[k]};
                rise = rise + 1;
            end
        end
        always @(negedge fclk[k] or posedge cs[k]) begin
            if (cs[k]) m = 1'b0;
            else       m = sbit(rise - Hdr);
        end
        assign miso[k]     = m;
        assign rise_arr[k] = rise;
        assign hdr_arr[k]  = hdr;
    end

    int          vecs = 0, errs = 0, tick = 0;
    int          n [2], cyc [2], runlen [2], stall [2];
    logic [31:0] sum [2], la [2], ld [2], first_a [2], first_d [2], last_a [2], last_d [2];
    logic [1:0]  lt [2];
    logic        pen [2], pdone [2], pfclk [2], cs_seen [2], hdr_done [2];

    task automatic chk(int k, string name, logic [63:0] act, logic [63:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s[%0d] t=%0t: actual %0h, required %0h", name, k, $time, act, req);
        end
    endtask

    task automatic compare_all();
        logic be;
        tick++;
        for (int k = 0; k < 2; k++) begin
            be = rbusy[k];
            if (!rst_n[k]) begin
                chk(k, "rst_busy", busy[k], 1);
                chk(k, "rst_done", done[k], 0);
                chk(k, "rst_en", ren[k], 0);
                chk(k, "rst_wtype", wtype[k], 0);
                chk(k, "rst_addr", addr[k], 0);
                chk(k, "rst_data", wdata[k], 0);
                chk(k, "rst_cs", cs[k], 1);
                chk(k, "rst_sclk", fclk[k], 0);
                chk(k, "rst_mosi", mosi[k], 0);
                n[k] = 0; sum[k] = 0; cyc[k] = 0; runlen[k] = 0; stall[k] = 0;
                cs_seen[k] = 0; hdr_done[k] = 0; pen[k] = 0; pdone[k] = 0; pfclk[k] = 0;
                first_a[k] = 32'hFFFF_FFFF; first_d[k] = 32'hFFFF_FFFF;
                rbusy[k] = 1'b0;
            end else begin
                cyc[k]++;
                chk(k, "busy_vs_done", busy[k], !done[k]);
                if (!cs_seen[k] && !cs[k]) begin
                    chk(k, "cs_fall_cycle", cyc[k], wait_of(k));
                    cs_seen[k] = 1;
                end
                if (cs[k]) hdr_done[k] = 0;
                else if (!hdr_done[k] && rise_arr[k] >= hdr_len(k)) begin
                    chk(k, "spi_header", hdr_arr[k], hdr_exp(k));
                    hdr_done[k] = 1;
                end
                if (cs[k]) runlen[k] = 0;
                else if (fclk[k] == pfclk[k]) runlen[k]++;
                else begin
                    if (pfclk[k]) chk(k, "sclk_high_len", runlen[k], half_of(k));
                    else if (rise_arr[k] <= hdr_len(k)) chk(k, "sclk_low_len", runlen[k], half_of(k));
                    runlen[k] = 1;
                end
                if (ren[k] && !pen[k]) begin
                    chk(k, "wr_waited_busy", be, 0);
                    chk(k, "wr_addr", addr[k], ram_base(k) + 32'(4 * n[k]));
                    chk(k, "wr_data", wdata[k], fw(n[k]));
                    chk(k, "wr_type", wtype[k], 2'b11);
                    chk(k, "wr_sclk_low", fclk[k], 0);
                    if (n[k] == 0) begin first_a[k] = addr[k]; first_d[k] = wdata[k]; end
                    la[k] = addr[k]; ld[k] = wdata[k]; lt[k] = wtype[k];
                    last_a[k] = addr[k]; last_d[k] = wdata[k];
                    sum[k] = sum[k] + fw(n[k]);
                    n[k]++;
                    if (k == 1) stall[k] = 5;
                end else if (ren[k]) begin
                    chk(k, "hold_addr", addr[k], la[k]);
                    chk(k, "hold_data", wdata[k], ld[k]);
                    chk(k, "hold_type", wtype[k], lt[k]);
                    chk(k, "hold_sclk", fclk[k], 0);
                end else if (pen[k]) begin
                    chk(k, "release_busy", be, 0);
                end
                if (done[k] && !pdone[k]) begin
                    chk(k, "done_words", n[k], words_of(k));
                    chk(k, "done_cs", cs[k], 1);
`ifdef FLASH_BOOT_CHECKSUM_EN
                    chk(k, "checksum", csum[k], sum[k]);
`endif
                end
                if (!done[k] && pdone[k]) begin
                    n[k] = 0;
                    sum[k] = 0;
                end
                pen[k] = ren[k]; pdone[k] = done[k]; pfclk[k] = fclk[k];
                if (k == 0) rbusy[k] = ((tick % 7) < 2);
                else if (stall[k] > 0) begin rbusy[k] = 1'b1; stall[k]--; end
                else rbusy[k] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst_n = 2'b11; start = 2'b00; rbusy = 2'b00;
        #2 rst_n = 2'b00;
        repeat (3) step();
        rst_n = 2'b11;

        for (int i = 0; i < 3000 && n[1] < 1; i++) step();
        chk(1, "first_write_seen", n[1], 1);
        chk(1, "first_addr_lit", first_a[1], 32'h100);
        chk(1, "first_data_lit", first_d[1], 32'h4433_2211);

        // Abort in the middle of the first write; cs must rise without a clock edge.
        rst_n[1] = 1'b0;
        #1;
        chk(1, "abort_cs", cs[1], 1);
        chk(1, "abort_en", ren[1], 0);
        chk(1, "abort_busy", busy[1], 1);
        chk(1, "abort_sclk", fclk[1], 0);
        repeat (2) step();
        rst_n[1] = 1'b1;

        // start while copying must be ignored
        repeat (20) step();
        start[1] = 1'b1;
        repeat (2) step();
        start[1] = 1'b0;

        for (int i = 0; i < 5000 && !done[1]; i++) step();
        chk(1, "run1_done", done[1], 1);
        chk(1, "run1_first_addr", first_a[1], 32'h100);
        chk(1, "run1_last_addr", last_a[1], 32'h104);
        chk(1, "run1_last_data", last_d[1], 32'h08E3_BE99);
`ifdef FLASH_BOOT_CHECKSUM_EN
        chk(1, "run1_checksum_lit", csum[1], 32'h4D16_E0AA);
`endif

        first_a[1] = 32'hFFFF_FFFF;
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        step();
        chk(1, "restart_busy", busy[1], 1);
        for (int i = 0; i < 5000 && !done[1]; i++) step();
        chk(1, "run2_done", done[1], 1);
        chk(1, "run2_first_addr", first_a[1], 32'h100);
        chk(1, "run2_last_addr", last_a[1], 32'h104);

        chk(0, "def_first_addr", first_a[0], 32'h0);
        chk(0, "def_first_data", first_d[0], 32'h4433_2211);
        chk(0, "def_progress", n[0] >= 3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/flash_boot_loader.md
FLASH_BOOT_LOADER -- requirements
Module: flash_boot_loader

Interface
REQ-001 SHALL have parameter StartupWaitCycles, default 10: clk cycles after reset before flash_cs falls.
REQ-002 SHALL have parameter FlashTransferBytes, default 32'h0010_0000: bytes copied; multiple of 4.
REQ-003 SHALL have parameter FlashStartAddress, default 24'h00_0000: 24-bit flash read address.
REQ-004 SHALL have parameter RamStartAddress, default 32'h0000_0000: first ramio byte address; 4-byte aligned.
REQ-005 SHALL have parameter SpiHalfPeriod, default 1: clk cycles per flash_clk phase; must be at least 1.
REQ-006 SHALL have parameter FastRead, default 0: 0 uses command 0x03; 1 uses command 0x0B followed by 8 dummy clocks.
REQ-007 SHALL have port clk, input, 1: clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-008 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1: re-run copy; honoured only in Done.
REQ-010 SHALL have port busy, output, 1: high from reset release until Done.
REQ-011 SHALL have port done, output, 1: high in Done.
REQ-012 SHALL have ports ramio_enable (output, 1), ramio_write_type (output, 2), ramio_address (output, 32), ramio_data_in (output, 32) and ramio_busy (input, 1): word-write master.
REQ-013 SHALL have ports flash_clk (output, 1), flash_miso (input, 1), flash_mosi (output, 1) and flash_cs (output, 1, active-low): SPI mode 0.

Function
REQ-014 SHALL use states Init, SendCmd, SendAddr, Dummy, ReadWord, StartWrite, Write, Done.
REQ-015 Init SHALL count StartupWaitCycles clk cycles, then drive flash_cs low and enter SendCmd; if FlashTransferBytes==0 it SHALL enter Done with flash_cs kept high.
REQ-016 Each SPI bit SHALL use SpiHalfPeriod cycles with flash_clk low and mosi updated at phase start, then SpiHalfPeriod cycles with flash_clk high.
REQ-017 flash_miso SHALL be shifted in on the cycle flash_clk rises.
REQ-018 SendCmd SHALL shift 8 command bits MSB first; SendAddr SHALL then shift FlashStartAddress as 24 bits MSB first.
REQ-019 Dummy SHALL be entered only when FastRead=1 and SHALL issue 8 clocks with mosi=0.
REQ-020 ReadWord SHALL collect 4 bytes, each MSB first, assembled little-endian (first byte -> ramio_data_in[7:0]).
REQ-021 StartWrite SHALL wait for ramio_busy==0, then assert ramio_enable=1, ramio_write_type=2'b11, ramio_address=RamStartAddress+4*n and data, and enter Write.
REQ-022 Write SHALL hold all ramio outputs until ramio_busy==0, then drive ramio_enable=0; it SHALL return to ReadWord if bytes remain, otherwise drive flash_cs high and enter Done.
REQ-023 flash_clk SHALL stay low while in StartWrite and Write, because the flash stream pauses.
REQ-024 In Done, start==1 SHALL re-enter Init with the counters cleared; start SHALL be ignored in every other state.
REQ-025 The byte counter SHALL be 32 bits; no address wrap SHALL occur within the parameter ranges.

Reset
REQ-026 On rst_n low the block SHALL force state=Init and drive busy=1, done=0, ramio_enable=0, ramio_write_type=0, ramio_address=0, ramio_data_in=0, flash_cs=1, flash_clk=0, flash_mosi=0, with all counters zeroed.
REQ-027 Reset mid-transfer SHALL abort immediately (flash_cs high in the same edge-free interval) and restart the copy from word 0 after release.

Configuration
REQ-028 With FLASH_BOOT_CHECKSUM_EN defined, the block SHALL have output checksum[31:0]: the wrapping 32-bit sum of all words written, cleared at Init, valid when done=1.
REQ-029 Without FLASH_BOOT_CHECKSUM_EN, the checksum port and adder SHALL be absent.

Verification
REQ-030 Defaults, flash model returning bytes 0x11,0x22,0x33,0x44 -> first write: address 0x0, data 0x44332211, write_type 2'b11.
REQ-031 FastRead=1 -> mosi shows 0x0B, then 24 address bits, then 8 clocks with mosi=0, then data is sampled.
REQ-032 SpiHalfPeriod=3 -> flash_clk high and low phases each measure 3 clk cycles.
REQ-033 ramio_busy held high for 5 cycles during Write -> outputs stable for those cycles, no flash_clk edges, and no data lost.
REQ-034 FlashTransferBytes=8, RamStartAddress=0x100 -> writes to 0x100 and 0x104, then done=1 and flash_cs=1; with checksum enabled, checksum equals the sum of both words.
REQ-035 rst_n pulsed low after the 1st word, then start pulsed in Done -> each run rewrites from RamStartAddress.
